// File: rtl/ps2_dir_rx.sv
// PS/2 device-to-host receiver with arrow/WASD decoding into
// four level-held direction outputs plus debug byte/error strobes.
module ps2_dir_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       right,
  output logic       left,
  output logic       down,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic clk_s1, clk_s2;
  logic dat_s1, dat_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  logic [FILTER_LEN-1:0] hist;
  logic                  all_hi;
  logic                  all_lo;
  logic                  fclk;
  logic                  fall;

  assign all_hi = &hist;
  assign all_lo = ~|hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '1;
      fclk <= 1'b1;
      fall <= 1'b0;
    end else begin
      hist <= {hist[FILTER_LEN-2:0], clk_s2};
      fall <= fclk & all_lo;
      if (fclk && all_lo)
        fclk <= 1'b0;
      else if (!fclk && all_hi)
        fclk <= 1'b1;
    end
  end

  state_t        state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic [7:0]    sh, sh_n;
  logic          par, par_n;
  logic [TW-1:0] tmo;
  logic          tmo_hit;
  logic          good;
  logic          bad;

  // Stall detection only runs mid-frame; the hit cycle itself
  // returns the FSM to IDLE, so the counter clears right after.
  assign tmo_hit = (state != IDLE) && !fall &&
                   (tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      par   <= 1'b0;
      tmo   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      par   <= par_n;
      if (state == IDLE || fall)
        tmo <= '0;
      else
        tmo <= tmo + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    par_n   = par;
    good    = 1'b0;
    bad     = 1'b0;
    if (tmo_hit) begin
      state_n = IDLE;
      bad     = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_n = DATA;
            cnt_n   = '0;
          end
        end
        DATA: begin
          sh_n  = {dat_s2, sh[7:1]};
          cnt_n = cnt + 1'b1;
          if (cnt == 3'd7)
            state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_s2;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (dat_s2 && (^{sh, par}))
            good = 1'b1;
          else
            bad = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_code  <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= good;
      frame_err  <= bad;
      if (good)
        scan_code <= sh;
    end
  end

  logic ext, brk;
  logic k_up, k_down, k_left, k_right;
  logic is_pfx;

  assign is_pfx = (scan_code == 8'hE0) || (scan_code == 8'hF0);

  always_comb begin
    k_up    = 1'b0;
    k_down  = 1'b0;
    k_left  = 1'b0;
    k_right = 1'b0;
    unique case (1'b1)
      ext: begin
        k_up    = scan_code == 8'h75;
        k_down  = scan_code == 8'h72;
        k_left  = scan_code == 8'h6B;
        k_right = scan_code == 8'h74;
      end
      default: begin
        k_up    = scan_code == 8'h1D;
        k_down  = scan_code == 8'h1B;
        k_left  = scan_code == 8'h1C;
        k_right = scan_code == 8'h23;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext   <= 1'b0;
      brk   <= 1'b0;
      up    <= 1'b0;
      down  <= 1'b0;
      left  <= 1'b0;
      right <= 1'b0;
    end else if (frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (code_valid) begin
      if (scan_code == 8'hE0)
        ext <= 1'b1;
      if (scan_code == 8'hF0)
        brk <= 1'b1;
      if (!is_pfx) begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (k_up)    up    <= ~brk;
        if (k_down)  down  <= ~brk;
        if (k_left)  left  <= ~brk;
        if (k_right) right <= ~brk;
      end
    end
  end

endmodule

// File: doc/ps2_dir_rx.md
# ps2_dir_rx

PS/2 keyboard receiver that deserialises device-to-host frames and decodes arrow-key and WASD make/break codes into four level-held direction signals. It sits on the input side of the game top level, beside the VGA/seven-segment output path. Its `up`/`right`/`left`/`down` outputs replace the raw push-button inputs of the snake controller. Received bytes and a frame-error strobe are also exported for debug display.

## Interface
- `FILTER_LEN`, 8: consecutive equal synchronized `ps2_clk` samples required to change the filtered clock level (2..31).
- `TIMEOUT_CYCLES`, 100000: `clk` cycles without a filtered falling edge before a partial frame is abandoned (1 ms at 100 MHz).
- `clk` input 1: system clock; the only clock.
- `rst` input 1: reset, asynchronous and active-low. All state clears on assertion.
- `ps2_clk` input 1: PS/2 clock from the pad; asynchronous, idles high.
- `ps2_data` input 1: PS/2 data from the pad; asynchronous, idles high.
- `up`, `right`, `left`, `down` output 1 each: high while the corresponding key is held.
- `scan_code` output 8: last correctly received byte.
- `code_valid` output 1: one-cycle pulse when `scan_code` updates.
- `frame_err` output 1: one-cycle pulse on a parity, stop or timeout error.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
  - Filtered clock `fclk` resets to 1. It takes the synchronized level once the last `FILTER_LEN` samples are all equal and differ from `fclk`.
  - `fall` is a 1-cycle strobe when `fclk` goes 1→0. Data is sampled from the synchronized `ps2_data` in that cycle.
- **Frame FSM** (reset state IDLE; transitions only on `fall` except timeout):
  - IDLE: if data=0 (start bit), go to DATA with bit count 0. If data=1, stay in IDLE silently.
  - DATA: shift in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: store the bit and go to STOP.
  - STOP: always go to IDLE. The frame is good when data=1 and the data bits plus parity bit have odd total ones. Good frame: load `scan_code` and pulse `code_valid`. Otherwise pulse `frame_err` and leave `scan_code` unchanged.
  - In any non-IDLE state, a timeout counter counts cycles since the last `fall`. When it reaches `TIMEOUT_CYCLES`: return to IDLE, pulse `frame_err`, discard the partial byte. The counter clears on every `fall` and in IDLE.
- **Decoder** (acts on `code_valid`):
  - 0xE0 sets `ext`. 0xF0 sets `brk`. Any other byte is a key byte: it is processed, then both flags clear.
  - Key map, extended (E0 prefix): 0x75 → up, 0x72 → down, 0x6B → left, 0x74 → right.
  - Key map, non-extended: 0x1D (W) → up, 0x1B (S) → down, 0x1C (A) → left, 0x23 (D) → right.
  - `brk`=0 sets the mapped output; `brk`=1 clears it.
  - Unmapped key bytes change no output but still clear the flags.
  - Outputs are independent: several may be high at once. Typematic repeats re-set an already-high output with no effect.
  - `frame_err` clears `ext` and `brk` but leaves direction outputs unchanged.

## Timing
- **Reset values:** `up`/`right`/`left`/`down` = 0, `scan_code` = 0x00, `code_valid` = 0, `frame_err` = 0; FSM in IDLE; `fclk` = 1; `ext` = `brk` = 0.
- **Filter latency:** a pin falling edge produces `fall` 2 + `FILTER_LEN` + 1 cycles later, provided the level holds.
- `code_valid` and `frame_err` are registered and assert the cycle after the stop-bit `fall`.
- Direction outputs update the cycle after the `code_valid` that carries the key byte.
- `code_valid` and `frame_err` are never high in the same cycle.
- **Reset mid-frame:** the partial frame is lost and the outputs return to their reset values. The next frame is received normally once a start bit is seen in IDLE.
- A glitch on `ps2_clk` shorter than `FILTER_LEN` cycles produces no `fall`.

## Test plan
- **Reset:** frame 0x1D sent while `rst`=0 → no `code_valid`, all outputs 0. After release, frame 0x1D → `code_valid` pulse, `scan_code`=0x1D, `up`=1 one cycle later.
- **Extended make/break:** E0,75 → `up`=1. E0,F0,75 → `up`=0. E0,6B followed by 1B → `left`=1 and `down`=1 simultaneously.
- **Errors:** byte 0x23 sent with even parity → `frame_err` pulse, `scan_code` unchanged, `right` stays 0. Good 0x23 with stop bit 0 → `frame_err` pulse.
- **Timeout:** start bit + 4 data bits, then idle for `TIMEOUT_CYCLES` → `frame_err` pulse exactly once, FSM in IDLE. Following good frame 0x1C → `left`=1.
- **Glitch/filter:** 3-cycle low pulse on `ps2_clk` with `FILTER_LEN`=8 → no bit sampled. Next full frame is received correctly.
- **Prefix flush:** E0 then 0x1B → `down`=1. E0, F0, then unmapped 0x5A → no change, flags clear. Then 0x1B → `down` stays 1 (make, not break).
